enable_table_loader: RTL

ENABLE_TABLE_LOADER -- requirements
Module: enable_table_loader

---
 rtl/enable_table_loader_pkg.sv | 30 +++
 rtl/enable_table_loader_entry_unpacker.sv | 17 +
 rtl/enable_table_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/enable_table_loader_pkg.sv
// Shared types and geometry for the enable-table loader: FSM states, table
// dimensions and the bit layout of one 2-bit table entry.
package enable_table_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    localparam int ENTRIES_PER_CONFIG = 512;
    localparam int BYTES_PER_CONFIG   = 128;
    localparam int ENTRIES_PER_BYTE   = 4;

    localparam int ENTRY_W = $clog2(ENTRIES_PER_CONFIG);
    localparam int SUB_W   = $clog2(ENTRIES_PER_BYTE);

    // Bit positions inside one table entry.
    localparam int TBL_RAM_BIT = 1;
    localparam int TBL_BUS_BIT = 0;

    function automatic logic [23:0] config_base(input logic [23:0] base,
                                                input logic [3:0]  sel);
        return base + (24'(sel) << $clog2(BYTES_PER_CONFIG));
    endfunction

endpackage

// File: rtl/enable_table_loader_entry_unpacker.sv
// Selects one 2-bit enable entry out of a config-store byte; entry n of a
// byte lives in bits [2n+1:2n].
module entry_unpacker
    import enable_table_loader_pkg::*;
(
    input  logic [7:0]       data_i,
    input  logic [SUB_W-1:0] sub_i,
    output logic [1:0]       val_o
);

    logic [1:0] pair;

    assign pair               = data_i[{sub_i, 1'b0} +: 2];
    assign val_o[TBL_RAM_BIT] = pair[1];
    assign val_o[TBL_BUS_BIT] = pair[0];

endmodule

// File: rtl/enable_table_loader.sv
// Loads one 512-entry enable table from the config store, one byte (four
// entries) at a time, holding the target CPU off until the table is complete.
module enable_table_loader
    import enable_table_loader_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR      = 24'h100000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        fpga_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  config_sel,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        table_we,
    output logic [8:0]  table_write_addr,
    output logic [1:0]  table_val,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int                 TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(ENTRIES_PER_CONFIG - 1);
    localparam logic [SUB_W-1:0]   LAST_SUB   = SUB_W'(ENTRIES_PER_BYTE - 1);

    state_e               state_q;
    logic [23:0]          addr_q;
    logic [ENTRY_W-1:0]   entry_q;
    logic [7:0]           data_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 rd_req_q;
    logic                 we_q;
    logic [1:0]           val_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 hold_q;

    logic [ENTRY_W-1:0]   entry_d;
    logic [7:0]           unpack_data_d;
    logic [SUB_W-1:0]     unpack_sub_d;
    logic [1:0]           val_d;

    assign entry_d = entry_q + 1'b1;

    // The first entry of a byte is unpacked straight from rd_data while it is
    // being captured; the remaining three come from the captured copy.
    assign unpack_data_d = (state_q == S_WAIT) ? rd_data : data_q;
    assign unpack_sub_d  = (state_q == S_WAIT) ? entry_q[SUB_W-1:0] : entry_d[SUB_W-1:0];

    entry_unpacker u_unpacker (
        .data_i (unpack_data_d),
        .sub_i  (unpack_sub_d),
        .val_o  (val_d)
    );

    // NOTE: every register below is assigned with <= so all of them update
    // together from the pre-edge values; blocking assignments here would let
    // later statements see half-updated state.
    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            entry_q  <= '0;
            data_q   <= '0;
            tmo_q    <= '0;
            rd_req_q <= 1'b0;
            we_q     <= 1'b0;
            val_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= config_base(BASE_ADDR, config_sel);
                        entry_q  <= '0;
                        error_q  <= 1'b0;
                        hold_q   <= 1'b1;
                        rd_req_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A response in the final timeout cycle still counts.
                    if (rd_valid) begin
                        data_q   <= rd_data;
                        rd_req_q <= 1'b0;
                        we_q     <= 1'b1;
                        val_q    <= val_d;
                        state_q  <= S_WRITE;
                    end else if (tmo_q == TMO_LAST) begin
                        rd_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        error_q  <= 1'b1;
                        state_q  <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (entry_q[SUB_W-1:0] != LAST_SUB) begin
                        entry_q <= entry_d;
                        val_q   <= val_d;
                    end else begin
                        we_q <= 1'b0;
                        if (entry_q == LAST_ENTRY) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            entry_q  <= entry_d;
                            addr_q   <= addr_q + 24'd1;
                            rd_req_q <= 1'b1;
                            state_q  <= S_REQ;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERROR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_req           = rd_req_q;
    assign rd_addr          = addr_q;
    assign table_we         = we_q;
    assign table_write_addr = entry_q;
    assign table_val        = val_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign cpu_hold         = hold_q;

endmodule
